riscv_regfile_scoreboard: RTL
=============================

RISCV_REGFILE_SCOREBOARD -- requirements
Module: riscv_regfile_scoreboard

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width.
REQ-002 SHALL have parameter NUM_REGS, default 32, architectural register count (power of two, >=2).
REQ-003 SHALL have parameter NUM_RD_PORTS, default 2, number of read ports (>=1).
REQ-004 SHALL define AW = $clog2(NUM_REGS) and CW = $clog2(NUM_REGS+1).
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port rd_addr  input  NUM_RD_PORTS x AW  read addresses.
REQ-008 SHALL have port rd_data  output  NUM_RD_PORTS x XLEN  read data.
REQ-009 SHALL have port issue_valid  input  1  an instruction with a destination leaves decode this cycle.
REQ-010 SHALL have port issue_rd  input  AW  destination register of the issued instruction.
REQ-011 SHALL have port wb_valid  input  1  writeback this cycle.
REQ-012 SHALL have port wb_addr  input  AW  writeback destination.
REQ-013 SHALL have port wb_data  input  XLEN  writeback value.
REQ-014 SHALL have port stall  output  1  a read address has a pending write not satisfied this cycle.
REQ-015 SHALL have port pending_cnt  output  CW  number of registers currently marked busy.

Function
REQ-016 Register 0 SHALL read as 0 on every port, SHALL never be written, and SHALL never be marked busy.
REQ-017 On rising clk with wb_valid=1 and wb_addr!=0, registers[wb_addr] SHALL take wb_data.
REQ-018 rd_data[p] SHALL be combinational: wb_data when wb_valid=1, wb_addr==rd_addr[p] and rd_addr[p]!=0 (write-through bypass); otherwise registers[rd_addr[p]].
REQ-019 Each register SHALL have a busy bit.
REQ-020 A register's busy bit SHALL set on the clock edge when issue_valid=1 and issue_rd names it, with issue_rd!=0.
REQ-021 A register's busy bit SHALL clear on the clock edge when wb_valid=1 and wb_addr names it.
REQ-022 When issue and writeback name the same register in one cycle, the busy bit SHALL end set (set wins); the data write still occurs.
REQ-023 stall SHALL be combinational: 1 iff, for some port p, rd_addr[p]!=0, busy[rd_addr[p]]=1, and not (wb_valid=1 and wb_addr==rd_addr[p]).
REQ-024 stall SHALL not depend on issue_valid/issue_rd in the same cycle.
REQ-025 pending_cnt SHALL be a registered value equal to the population count of the busy bits after each edge, range 0..NUM_REGS-1.
REQ-026 Writeback to a non-busy register SHALL update data and SHALL not change any busy bit or pending_cnt.
REQ-027 Re-issue to an already-busy register SHALL keep it busy and SHALL not increment pending_cnt.
REQ-028 Multiple read ports addressing the same register SHALL return identical data.

Reset
REQ-029 While rst_n=0, all registers SHALL be 0, all busy bits 0, and pending_cnt 0, asynchronously, independent of clk.
REQ-030 During reset, stall SHALL be 0 and rd_data SHALL reflect zeroed registers, except that the REQ-018 bypass still applies.
REQ-031 Reset asserted mid-operation SHALL discard all pending marks; a writeback arriving on the first edge after release SHALL be applied normally.

Verification
REQ-032 Write-then-read test: after reset, wb x1=10 and then x2=20 on consecutive edges; read x1 on port0 and x2 on port1 -> rd_data = 10 and 20, stall=0.
REQ-033 Bypass test: wb_valid=1, wb_addr=3, wb_data=30 with rd_addr[0]=3 in the same cycle -> rd_data[0]=30 before the edge; after the edge, registers[3]=30.
REQ-034 Load-use stall test: issue_rd=4; next cycle rd_addr[0]=4 -> stall=1 and pending_cnt=1; then wb x4=40 -> stall=0 combinationally in that cycle, rd_data[0]=40, and pending_cnt=0 after the edge.
REQ-035 x0 test: issue_rd=0 and wb x0=99 -> pending_cnt stays 0, and rd_data=0 on all ports with rd_addr=0.
REQ-036 Collision test: x5 busy; issue_rd=5 and wb x5=60 in the same cycle -> after the edge registers[5]=60, x5 still busy, pending_cnt=1, and reading x5 gives stall=1.
REQ-037 Reset test: mark x6 and x7 busy, then pulse rst_n low between clock edges -> pending_cnt=0, registers 0, and stall=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/riscv_regfile_scoreboard.sv
// Integer register file with write-through read ports and a per-register busy
// scoreboard that flags load-use hazards and tracks outstanding destinations.

module riscv_regfile_scoreboard_rdport #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic [AW-1:0]                      addr_i,
    input  logic [NUM_REGS-1:0][XLEN-1:0]      regs_i,
    input  logic [NUM_REGS-1:0]                busy_i,
    input  logic                               wb_valid_i,
    input  logic [AW-1:0]                      wb_addr_i,
    input  logic [XLEN-1:0]                    wb_data_i,
    output logic [XLEN-1:0]                    data_o,
    output logic                               stall_o
);
    logic nz;
    logic hit;

    assign nz  = (addr_i != '0);
    assign hit = wb_valid_i && (wb_addr_i == addr_i);

    // A same-cycle writeback both forwards its data and satisfies the hazard.
    assign data_o  = !nz ? '0 : (hit ? wb_data_i : regs_i[addr_i]);
    assign stall_o = nz && busy_i[addr_i] && !hit;
endmodule

module riscv_regfile_scoreboard #(
    parameter int XLEN         = 32,
    parameter int NUM_REGS     = 32,
    parameter int NUM_RD_PORTS = 2,
    parameter int AW           = $clog2(NUM_REGS),
    parameter int CW           = $clog2(NUM_REGS + 1)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_RD_PORTS-1:0][AW-1:0]     rd_addr,
    output logic [NUM_RD_PORTS-1:0][XLEN-1:0]   rd_data,
    input  logic                                issue_valid,
    input  logic [AW-1:0]                       issue_rd,
    input  logic                                wb_valid,
    input  logic [AW-1:0]                       wb_addr,
    input  logic [XLEN-1:0]                     wb_data,
    output logic                                stall,
    output logic [CW-1:0]                       pending_cnt
);
    logic [NUM_REGS-1:0][XLEN-1:0] regs_q;
    logic [NUM_REGS-1:0]           busy_q, busy_d;
    logic [CW-1:0]                 cnt_q, cnt_d;
    logic [NUM_RD_PORTS-1:0]       stall_lane;

    // Clear on writeback first so a same-register issue in the same cycle wins.
    always_comb begin
        busy_d = busy_q;
        if (wb_valid)
            busy_d[wb_addr] = 1'b0;
        if (issue_valid && (issue_rd != '0))
            busy_d[issue_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < NUM_REGS; i++)
            cnt_d = cnt_d + CW'(busy_d[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '0;
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (wb_valid && (wb_addr != '0))
                regs_q[wb_addr] <= wb_data;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
        riscv_regfile_scoreboard_rdport #(
            .XLEN     (XLEN),
            .NUM_REGS (NUM_REGS),
            .AW       (AW)
        ) u_rd (
            .addr_i     (rd_addr[p]),
            .regs_i     (regs_q),
            .busy_i     (busy_q),
            .wb_valid_i (wb_valid),
            .wb_addr_i  (wb_addr),
            .wb_data_i  (wb_data),
            .data_o     (rd_data[p]),
            .stall_o    (stall_lane[p])
        );
    end

    assign stall       = |stall_lane;
    assign pending_cnt = cnt_q;
endmodule
